uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clk cycles per UART bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of transmit FIFO entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic sits in this domain.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port tx_data, input, 8 bits: byte offered for transmission.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data is valid this cycle.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte this cycle.
REQ-008 The block SHALL have port UART_RXD_OUT, output, 1 bit: serial line to the host, registered, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.
REQ-010 The block SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-011 A byte SHALL be accepted on a rising clk edge where tx_valid=1 and tx_ready=1; no other condition writes the FIFO.
REQ-012 tx_ready SHALL equal (fifo_count != FIFO_DEPTH), combinationally from registered state, independent of any same-cycle pop.
REQ-013 A push and a pop on the same edge SHALL leave fifo_count unchanged and preserve FIFO order.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 Frame format SHALL be 8N1: start bit 0, data bits 0..7 LSB first, one stop bit 1, each lasting exactly CLKS_PER_BIT cycles.
REQ-016 IDLE: UART_RXD_OUT=1; on the first edge where fifo_count!=0, the FSM SHALL pop the head byte into a shift register, enter START, and drive UART_RXD_OUT=0.
REQ-017 Latency: if a byte is accepted into an empty FIFO at edge E while in IDLE, UART_RXD_OUT SHALL be 0 from edge E+1.
REQ-018 A bit counter (0..CLKS_PER_BIT-1) SHALL advance every cycle outside IDLE; the bit boundary SHALL occur when it wraps to 0.
REQ-019 START->DATA after CLKS_PER_BIT cycles; DATA SHALL shift out 8 bits using a 3-bit index, then go to STOP; STOP SHALL drive 1 for CLKS_PER_BIT cycles.
REQ-020 At the end of STOP, if the FIFO is non-empty, the FSM SHALL pop and enter START on the same edge (zero idle gap); otherwise it SHALL enter IDLE.
REQ-021 A complete frame SHALL occupy exactly 10*CLKS_PER_BIT cycles.
REQ-022 busy SHALL be (state!=IDLE) or (fifo_count!=0).
REQ-023 Bytes offered while tx_ready=0 SHALL be ignored and not corrupt FIFO contents; the source holds tx_valid/tx_data until acceptance.
REQ-024 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-025 While rst_n=0: UART_RXD_OUT=1, state=IDLE, counters=0, fifo_count=0, busy=0, tx_ready=1, FIFO writes ignored.
REQ-026 Assertion mid-frame SHALL force UART_RXD_OUT high immediately (asynchronously), discard the partial frame and all FIFO contents; no residual frame SHALL follow release.
REQ-027 After release, the block SHALL accept a byte on the first rising edge with tx_valid=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single byte 0x55 pushed at edge E -> line 0 from E+1; then 1,0,1,0,1,0,1,0, then stop 1, each 4 cycles; busy falls at E+41; line stays 1.
REQ-029 Back-to-back 0xA5 then 0x3C -> 80 contiguous cycles: 0,1,0,1,0,0,1,0,1,1, 0,0,0,1,1,1,1,0,0,1 (4 cycles each); no idle-high gap between frames.
REQ-030 tx_valid held high with 6 bytes from idle -> bytes 0..4 accepted on consecutive edges (byte 0 popped at once); tx_ready=0 with fifo_count=4; byte 5 accepted on the edge after the first frame's stop bit ends; output order = input order.
REQ-031 Reset pulse at cycle 15 of a frame with 2 bytes queued -> line 1 immediately, fifo_count=0, busy=0; no further transitions on the line after release.
REQ-032 Push while full, at the same edge as a pop -> push refused (tx_ready=0); fifo_count drops by 1; the refused byte is accepted on the next edge.
REQ-033 CLKS_PER_BIT=434, byte 0x00 -> line low for exactly 3906 cycles, then high for 434.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter fed by a small byte FIFO
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tx_data      byte offered for transmission
//   tx_valid     tx_data is valid this cycle
//   tx_ready     FIFO can accept a byte this cycle
//   UART_RXD_OUT registered serial line, idle high
//   busy         frame in progress or FIFO non-empty
//   fifo_count   current FIFO occupancy
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        UART_RXD_OUT,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [AW:0]   FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        r_state, w_state_next;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_line, w_line_next, w_push, w_pop, w_tick, w_nonempty;

    assign tx_ready     = r_count != FULL;
    assign w_push       = tx_valid && tx_ready;
    assign w_nonempty   = r_count != '0;
    assign w_tick       = r_clk_cnt == LAST;
    assign UART_RXD_OUT = r_line;
    assign busy         = (r_state != IDLE) || w_nonempty;
    assign fifo_count   = r_count;

    // Storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push != w_pop) r_count <= w_push ? r_count + (AW+1)'(1) : r_count - (AW+1)'(1);
        end
    end

    // Next state and next line value; a pop happens from IDLE or at the end of STOP.
    always_comb begin
        w_state_next = r_state;
        w_line_next  = r_line;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: if (w_nonempty) begin
                w_pop        = 1'b1;
                w_state_next = START;
                w_line_next  = 1'b0;
            end
            START: if (w_tick) begin
                w_state_next = DATA;
                w_line_next  = r_shift[0];
            end
            DATA: if (w_tick) begin
                w_state_next = (r_bit_idx == 3'd7) ? STOP : DATA;
                w_line_next  = (r_bit_idx == 3'd7) ? 1'b1 : r_shift[1];
            end
            STOP: if (w_tick) begin
                w_pop        = w_nonempty;
                w_state_next = w_nonempty ? START : IDLE;
                w_line_next  = !w_nonempty;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_line    <= 1'b1;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_line    <= w_line_next;
            r_clk_cnt <= (r_state == IDLE || w_tick) ? '0 : r_clk_cnt + CW'(1);
            if (w_pop) begin
                r_shift   <= r_mem[r_rd_ptr];
                r_bit_idx <= '0;
            end else if (r_state == DATA && w_tick) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx with a queue-based line model and a serial receiver
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, line, busy;
    logic [2:0] fifo_count;

    logic [7:0] b_data = 8'h00;
    logic       b_valid = 1'b0;
    logic       b_ready, b_line, b_busy;
    logic [2:0] b_count;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .UART_RXD_OUT(line), .busy(busy), .fifo_count(fifo_count)
    );

    uart_tx #(.CLKS_PER_BIT(434), .FIFO_DEPTH(DEPTH)) u_big (
        .clk(clk), .rst_n(rst_n), .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready),
        .UART_RXD_OUT(b_line), .busy(b_busy), .fifo_count(b_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a byte queue, the line as a queue of per-cycle bit values.
    logic [7:0] m_q[$];
    bit         m_bits[$];
    bit         m_active = 1'b0;
    bit         m_line = 1'b1;
    int         m_pre;
    bit         m_acc;
    logic [7:0] m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_bits.delete();
            m_active = 1'b0;
            m_line = 1'b1;
        end else begin
            m_pre = m_q.size();
            m_acc = tx_valid && (m_pre != DEPTH);
            if (m_bits.size() == 0 && m_pre != 0) begin
                m_b = m_q.pop_front();
                for (int p = 0; p < 10; p++)
                    repeat (CPB) m_bits.push_back(p == 0 ? 1'b0 : p == 9 ? 1'b1 : m_b[p-1]);
            end
            if (m_bits.size() != 0) begin
                m_line = m_bits.pop_front();
                m_active = 1'b1;
            end else begin
                m_line = 1'b1;
                m_active = 1'b0;
            end
            if (m_acc) m_q.push_back(tx_data);
        end
    end

    always @(negedge clk) begin
        chk("line", line, m_line);
        chk("busy", busy, m_active || m_q.size() != 0);
        chk("count", fifo_count, m_q.size());
        chk("ready", tx_ready, m_q.size() != DEPTH);
    end

    // Serial receiver sampling each bit at its centre.
    logic [7:0] rx_q[$];
    bit         rx_on = 1'b0;
    int         rx_t;
    logic [7:0] rx_b;

    always @(negedge clk) begin
        if (!rst_n) rx_on = 1'b0;
        else if (!rx_on) begin
            if (line == 1'b0) begin
                rx_on = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2 && rx_t / CPB >= 1 && rx_t / CPB <= 8) rx_b[rx_t/CPB-1] = line;
            if (rx_t == 9 * CPB + CPB / 2) begin
                chk("rx_stop", line, 1);
                rx_q.push_back(rx_b);
                rx_on = 1'b0;
            end
        end
    end

    task automatic wave(input string name, input logic [19:0] bits, input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < CPB; j++) begin
                chk(name, line, bits[n-1-i]);
                @(negedge clk);
            end
    endtask

    logic [7:0] v[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int low, high;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_line", line, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", tx_ready, 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // single byte 0x55
        tx_data = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("lat_pre", line, 1);
        @(negedge clk);
        wave("frame_55", 20'b0101010101, 10);
        chk("busy_fall", busy, 0);
        chk("idle_line", line, 1);

        // back-to-back 0xA5, 0x3C
        repeat (3) @(negedge clk);
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h3C;
        @(negedge clk);
        tx_valid = 1'b0;
        wave("frame_a5_3c", 20'b01010010110001111001, 20);
        chk("b2b_busy_fall", busy, 0);

        // six bytes with tx_valid held; full FIFO and refused push at pop edge
        rx_q.delete();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            tx_data = v[k];
            tx_valid = 1'b1;
            @(negedge clk);
        end
        tx_data = v[5];
        chk("full_count", fifo_count, 4);
        chk("full_ready", tx_ready, 0);
        repeat (36) @(negedge clk);
        chk("still_full_count", fifo_count, 4);
        chk("still_full_ready", tx_ready, 0);
        @(negedge clk);
        chk("pop_refused_count", fifo_count, 3);
        chk("pop_refused_ready", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("late_accept_count", fifo_count, 4);
        for (int i = 0; i < 400 && busy; i++) @(negedge clk);
        chk("drain_busy", busy, 0);
        chk("rx_n", rx_q.size(), 6);
        for (int k = 0; k < 6; k++)
            chk("rx_order", (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, v[k]);

        // reset mid-frame with two bytes queued
        repeat (2) @(negedge clk);
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h12;
        @(negedge clk);
        tx_data = 8'h34;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_rst_line", line, 0);
        chk("pre_rst_count", fifo_count, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_line", line, 1);
        chk("async_count", fifo_count, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", tx_ready, 1);
        tx_data = 8'h77;
        tx_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("quiet_line", line, 1);
            chk("quiet_busy", busy, 0);
        end

        // first edge after release accepts
        rst_n = 1'b0;
        @(negedge clk);
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("first_edge_accept", fifo_count, 1);
        @(negedge clk);
        wave("frame_5a", 20'b0010110101, 10);
        chk("f5a_busy_fall", busy, 0);

        // CLKS_PER_BIT=434, byte 0x00
        b_data = 8'h00;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("big_lat_pre", b_line, 1);
        @(negedge clk);
        low = 0;
        for (int i = 0; i < 5000 && b_line == 1'b0; i++) begin
            low++;
            @(negedge clk);
        end
        chk("big_low", low, 3906);
        high = 0;
        for (int i = 0; i < 1000 && b_line == 1'b1 && b_busy; i++) begin
            high++;
            @(negedge clk);
        end
        chk("big_high", high, 434);
        chk("big_idle_line", b_line, 1);
        chk("big_idle_busy", b_busy, 0);
        chk("big_count", b_count, 0);
        chk("big_ready", b_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
